// File: rtl/count_scheduler.sv
// Shared up-counter scheduler: grants one requester at a time,
// counts 0..len, then pulses done. Define SCHED_FIXED_PRIO_EN for fixed priority.
module count_scheduler #(
   parameter int NREQ = 4,
   parameter int CW   = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   len,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [IDW-1:0]       cur_id,
   output logic [CW-1:0]        count,
   output logic [NREQ-1:0]      done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state;
   logic [CW-1:0]      len_q;
   logic               sel_any;
   logic [IDW-1:0]     sel_id;
   logic [CW-1:0]      sel_len;
   logic [IDW:0]       off;
   logic [IDW:0]       sum;
   logic [NREQ-1:0]    rot;
   logic               cur_req;
   logic [IDW-1:0]     nxt_id;

`ifndef SCHED_FIXED_PRIO_EN
   logic [IDW-1:0]     ptr;
   logic [2*NREQ-1:0]  dbl;
`endif

   // pick the winner: first set req at or above the pointer, wrapping
   always_comb begin
      sel_any = |req;
`ifdef SCHED_FIXED_PRIO_EN
      rot = req;
`else
      dbl = {req, req} >> ptr;
      rot = dbl[NREQ-1:0];
`endif
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = (IDW+1)'(k);
         end
      end
`ifdef SCHED_FIXED_PRIO_EN
      sum = off;
`else
      sum = {1'b0, ptr} + off;
      if (sum >= (IDW+1)'(NREQ)) begin
         sum = sum - (IDW+1)'(NREQ);
      end
`endif
      sel_id = sum[IDW-1:0];
      sel_len = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel_id == IDW'(k)) begin
            sel_len = len[k*CW +: CW];
         end
      end
   end

   // live request of the granted requester, and its round-robin successor
   always_comb begin
      cur_req = |(req & gnt);
      if (cur_id == IDW'(NREQ - 1)) begin
         nxt_id = '0;
      end else begin
         nxt_id = cur_id + 1'b1;
      end
   end

   // grant / count / done sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         gnt    <= '0;
         done   <= '0;
         busy   <= 1'b0;
         count  <= '0;
         cur_id <= '0;
         len_q  <= '0;
`ifndef SCHED_FIXED_PRIO_EN
         ptr    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               count <= '0;
               if (sel_any) begin
                  state  <= RUN;
                  gnt    <= NREQ'(1) << sel_id;
                  cur_id <= sel_id;
                  busy   <= 1'b1;
                  len_q  <= sel_len;
               end
            end
            RUN: begin
               if (!cur_req) begin
                  state <= IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
                  count <= '0;
`ifndef SCHED_FIXED_PRIO_EN
                  ptr   <= nxt_id;
`endif
               end else if (count == len_q) begin
                  state <= DONE;
                  gnt   <= '0;
                  done  <= NREQ'(1) << cur_id;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               busy  <= 1'b0;
               count <= '0;
`ifndef SCHED_FIXED_PRIO_EN
               ptr   <= nxt_id;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler: vector table plus
// hand sequences for len extremes, abort and mid-run reset.
module tb_count_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] len = '0;
   logic [3:0]  gnt;
   logic        busy;
   logic [1:0]  cur_id;
   logic [3:0]  count;
   logic [3:0]  done;

   int tests = 0;
   int fails = 0;

   count_scheduler #(
      .NREQ (4),
      .CW   (4),
      .IDW  (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .len    (len),
      .gnt    (gnt),
      .busy   (busy),
      .cur_id (cur_id),
      .count  (count),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [15:0] len;
      logic [3:0]  gnt;
      logic [3:0]  done;
      logic        busy;
      logic [3:0]  count;
      logic [1:0]  id;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] rq,
                               input logic [15:0] ln, input logic [3:0] g,
                               input logic [3:0] d, input logic b,
                               input logic [3:0] c, input logic [1:0] id);
      vec_t v;
      v.rst = r; v.req = rq; v.len = ln; v.gnt = g;
      v.done = d; v.busy = b; v.count = c; v.id = id;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // gnt/done exclusivity and one-hotness on every cycle out of reset
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("gnt_done_excl", 32'((|gnt) && (|done)), 0);
         chk("gnt_onehot", 32'($onehot0(gnt)), 1);
         chk("done_onehot", 32'($onehot0(done)), 1);
      end
   end

   initial begin
      logic [1:0] id;
      logic [3:0] oh;

      // reset row
      add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, 2'd0);
      // single requester, len0=3
      add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd0, 2'd0);
      add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd1, 2'd0);
      add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd2, 2'd0);
      add(1, 4'h1, 16'h0003, 4'h1, 4'h0, 1, 4'd3, 2'd0);
      add(1, 4'h1, 16'h0003, 4'h0, 4'h1, 1, 4'd3, 2'd0);
      add(1, 4'h0, 16'h0003, 4'h0, 4'h0, 0, 4'd0, 2'd0);
      add(1, 4'h0, 16'h0003, 4'h0, 4'h0, 0, 4'd0, 2'd0);
      // reset again so arbitration restarts at requester 0
      add(0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'd0, 2'd0);
      // all four requesting, every len=1
      id = '0;
      for (int g = 0; g < 5; g++) begin
`ifdef SCHED_FIXED_PRIO_EN
         id = 2'd0;
`else
         id = 2'(g % 4);
`endif
         oh = 4'h1 << id;
         add(1, 4'hF, 16'h1111, oh, 4'h0, 1, 4'd0, id);
         add(1, 4'hF, 16'h1111, oh, 4'h0, 1, 4'd1, id);
         if (g < 4) begin
            add(1, 4'hF, 16'h1111, 4'h0, oh, 1, 4'd1, id);
            add(1, 4'hF, 16'h1111, 4'h0, 4'h0, 0, 4'd0, id);
         end
      end
      // abort right after grant: no done
      add(1, 4'h0, 16'h1111, 4'h0, 4'h0, 0, 4'd0, id);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         req = vecs[i].req;
         len = vecs[i].len;
         step();
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].count));
         chk($sformatf("v%0d_id", i), 32'(cur_id), 32'(vecs[i].id));
      end

      // len2=0: one-cycle grant
      req = 4'h4;
      len = 16'h0000;
      step();
      chk("len0_gnt", 32'(gnt), 32'h4);
      chk("len0_cnt", 32'(count), 0);
      chk("len0_id", 32'(cur_id), 2);
      step();
      chk("len0_gnt_off", 32'(gnt), 0);
      chk("len0_done", 32'(done), 32'h4);
      chk("len0_cnt_hold", 32'(count), 0);
      step();
      chk("len0_idle_busy", 32'(busy), 0);
      chk("len0_idle_done", 32'(done), 0);

      // len2=15: sixteen-cycle grant, len change mid-run ignored
      len = 16'h0F00;
      step();
      chk("len15_gnt", 32'(gnt), 32'h4);
      chk("len15_cnt0", 32'(count), 0);
      len = 16'h0000;
      for (int i = 1; i < 16; i++) begin
         step();
         chk($sformatf("len15_cnt%0d", i), 32'(count), 32'(i));
         chk($sformatf("len15_gnt%0d", i), 32'(gnt), 32'h4);
      end
      step();
      chk("len15_done", 32'(done), 32'h4);
      chk("len15_peak", 32'(count), 15);
      chk("len15_gnt_off", 32'(gnt), 0);
      step();
      chk("len15_idle_cnt", 32'(count), 0);
      chk("len15_idle_busy", 32'(busy), 0);

      // abort at count=3, pending req1 gets the next grant
      req = 4'h3;
      len = 16'h00F7;
      step();
      chk("ab_gnt0", 32'(gnt), 32'h1);
      chk("ab_id0", 32'(cur_id), 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("ab_cnt%0d", i), 32'(count), 32'(i));
         chk($sformatf("ab_nodone%0d", i), 32'(done), 0);
      end
      req = 4'h2;
      step();
      chk("ab_gnt_off", 32'(gnt), 0);
      chk("ab_cnt_clr", 32'(count), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_nodone", 32'(done), 0);
      step();
      chk("ab_next_gnt", 32'(gnt), 32'h2);
      chk("ab_next_id", 32'(cur_id), 1);
      chk("ab_next_cnt", 32'(count), 0);

      // asynchronous reset at count=5
      for (int i = 0; i < 5; i++) begin
         step();
      end
      chk("rs_cnt5", 32'(count), 5);
      #1;
      rst = 1'b0;
      #1;
      chk("rs_gnt", 32'(gnt), 0);
      chk("rs_cnt", 32'(count), 0);
      chk("rs_done", 32'(done), 0);
      chk("rs_busy", 32'(busy), 0);
      step();
      rst = 1'b1;
      req = 4'h2;
      step();
      chk("rs_regrant", 32'(gnt), 32'h2);
      chk("rs_regrant_id", 32'(cur_id), 1);
      chk("rs_regrant_cnt", 32'(count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/count_scheduler.md
Name: count_scheduler

Overview:
- Arbitrates one shared up-counter among NREQ requesters.
- Each requester asks for a run of a programmed length. The block grants round-robin, runs the counter from 0 to the requested terminal value, then pulses a per-requester done.
- Sits between requesting control logic and the counter datapath. The count output feeds downstream timing and strobe logic.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 4, counter width in bits
- IDW, 2, width of cur_id; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req  input  NREQ  level request per requester; held high until done or abandoned
- len  input  NREQ*CW  terminal count per requester; requester i uses len[i*CW +: CW]
- gnt  output  NREQ  one-hot grant, registered
- busy  output  1  high while in RUN or DONE
- cur_id  output  IDW  index of granted or last-granted requester
- count  output  CW  shared counter value
- done  output  NREQ  one-cycle completion pulse, one-hot, registered

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt=0, done=0, busy=0, count=0, cur_id=0.
  - Round-robin pointer set so that requester 0 has top priority.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - At that edge: state=RUN, gnt[i]=1, cur_id=i, count=0, busy=1, len_q=len[i].
  - The len value is latched only at grant; later changes to len are ignored for the current run.
  - If no req bit is set, stay in IDLE with count=0.
- RUN:
  - Each edge with req[cur_id]=1 and count!=len_q: count<=count+1.
  - Edge with req[cur_id]=1 and count==len_q: state=DONE, gnt=0, done[cur_id]=1, count held at len_q.
  - Grant lasts exactly len_q+1 cycles. len_q=0 gives one RUN cycle.
  - Abort: if req[cur_id]=0 at an edge in RUN, go to IDLE. That edge sets gnt=0, busy=0, count=0. No done pulse is produced.
  - Abort has priority over the terminal-count check on the same edge.
- DONE:
  - Lasts one cycle. Next edge: done=0, busy=0, count=0, state=IDLE.
- Pointer update: after DONE or abort, the pointer becomes cur_id+1 modulo NREQ. The just-served requester drops to lowest priority.
- Other requesters' req changes during RUN or DONE are ignored until IDLE.
- At least one IDLE cycle separates consecutive grants.
- No arithmetic overflow: count never exceeds len_q, which is at most 2**CW-1.
- Reset asserted mid-RUN clears all state immediately, with no done pulse. After reset release the first edge is evaluated in IDLE.
- Invariants: gnt and done are never both nonzero. gnt and done are each at most one-hot.

Optional Feature:
- Macro: SCHED_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, where the lowest set req index always wins. The pointer is neither updated nor used.
- Undefined (default): round-robin as described above.
- Timing, states and abort rules are identical in both modes.

Test Plan:
- Single requester: req=0001, len0=3 → gnt[0] high 4 cycles with count 0,1,2,3; next cycle done=0001 for 1 cycle; next cycle count=0, busy=0.
- Round-robin: req=1111 held, all len=1 → grant order 0,1,2,3,0. Each grant is 2 cycles, followed by 1 DONE cycle and 1 IDLE cycle.
- len=0 and len=15 (CW=4) on requester 2 → 1-cycle and 16-cycle grants respectively; count peaks at 0 and 15, with no wrap.
- Abort: req0 with len0=7 granted; drop req0 when count=3 → next edge gnt=0, count=0, no done. A pending req1 is granted on the following IDLE edge.
- Reset mid-run: rst=0 at count=5 → gnt, count, done and busy go to 0 asynchronously, before the next clk edge. After release with req=0010, the first grant goes to requester 1.
- With SCHED_FIXED_PRIO_EN defined: req=1111 held → requester 0 is granted repeatedly; requesters 1–3 are never granted while req0 stays high.
